// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs behind a 4-word window.
// CPU side runs off the M-stage; UART side uses valid/ready handshakes.
module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    input  logic        stall,
    output logic        sel,
    output logic [31:0] rdata,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);

    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXCW = TXAW + 1;
    localparam int RXCW = RXAW + 1;

    logic [7:0]      txMem [TX_DEPTH];
    logic [TXAW-1:0] txRdPtr;
    logic [TXAW-1:0] txWrPtr;
    logic [TXCW-1:0] txCount;
    logic            txOverflow;

    logic [7:0]      rxMem [RX_DEPTH];
    logic [RXAW-1:0] rxRdPtr;
    logic [RXAW-1:0] rxWrPtr;
    logic [RXCW-1:0] rxCount;
    logic            rxEmptyRead;

    logic isStatus;
    logic isTx;
    logic isRx;
    logic cpuWr;
    logic cpuRd;

    logic txFull;
    logic txPush;
    logic txDrop;
    logic txPop;
    logic txFlush;

    logic rxEmpty;
    logic rxCap;
    logic rxRdAcc;
    logic rxPop;

    logic [31:0] statusWord;
    logic        unusedAddr;

    assign unusedAddr = &{1'b0, addr[27:4], addr[1:0]};

    assign sel      = (addr[31:28] == 4'b1000);
    assign isStatus = (addr[3:2] == 2'd0);
    assign isTx     = (addr[3:2] == 2'd2);
    assign isRx     = (addr[3:2] == 2'd3);
    assign cpuWr    = sel & we & ~stall;
    assign cpuRd    = sel & re & ~stall;

    // Space is judged on the registered count only; a same-edge
    // pop never makes room for the push.
    assign txFull  = (txCount == TXCW'(TX_DEPTH));
    assign txPush  = cpuWr & isTx & ~txFull;
    assign txDrop  = cpuWr & isTx & txFull;
    assign txFlush = cpuWr & isStatus & wdata[4];
    assign txPop   = DataInValid & DataInReady;

    assign DataInValid = (txCount != '0);
    assign DataIn      = DataInValid ? txMem[txRdPtr] : 8'h00;

    assign rxEmpty      = (rxCount == '0);
    assign DataOutReady = (rxCount != RXCW'(RX_DEPTH));
    assign rxCap        = DataOutValid & DataOutReady;
    assign rxRdAcc      = cpuRd & isRx;
    assign rxPop        = rxRdAcc & ~rxEmpty;

    assign statusWord = {
        20'h0,
        4'(rxCount),
        4'(txCount),
        rxEmptyRead,
        txOverflow,
        ~rxEmpty,
        ~txFull
    };

    always_comb begin
        rdata = 32'h0;
        if (sel && re) begin
            unique case (1'b1)
                isStatus: rdata = statusWord;
                isRx:     rdata = rxEmpty ? 32'h0 : {24'h0, rxMem[rxRdPtr]};
                default:  rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[txWrPtr] <= wdata;
        end
        if (rxCap) begin
            rxMem[rxWrPtr] <= DataOut;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txRdPtr <= '0;
            txWrPtr <= '0;
            txCount <= '0;
        end else if (txFlush) begin
            txRdPtr <= '0;
            txWrPtr <= '0;
            txCount <= '0;
        end else begin
            if (txPush) begin
                txWrPtr <= txWrPtr + TXAW'(1);
            end
            if (txPop) begin
                txRdPtr <= txRdPtr + TXAW'(1);
            end
            unique case ({txPush, txPop})
                2'b10:   txCount <= txCount + TXCW'(1);
                2'b01:   txCount <= txCount - TXCW'(1);
                default: txCount <= txCount;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxRdPtr <= '0;
            rxWrPtr <= '0;
            rxCount <= '0;
        end else begin
            if (rxCap) begin
                rxWrPtr <= rxWrPtr + RXAW'(1);
            end
            if (rxPop) begin
                rxRdPtr <= rxRdPtr + RXAW'(1);
            end
            unique case ({rxCap, rxPop})
                2'b10:   rxCount <= rxCount + RXCW'(1);
                2'b01:   rxCount <= rxCount - RXCW'(1);
                default: rxCount <= rxCount;
            endcase
        end
    end

    // A clear and a set in the same cycle resolve to set, so an
    // error event is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txOverflow  <= 1'b0;
            rxEmptyRead <= 1'b0;
        end else begin
            if (txDrop) begin
                txOverflow <= 1'b1;
            end else if (cpuWr && isStatus && wdata[2]) begin
                txOverflow <= 1'b0;
            end
            if (rxRdAcc && rxEmpty) begin
                rxEmptyRead <= 1'b1;
            end else if (cpuWr && isStatus && wdata[3]) begin
                rxEmptyRead <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: vector table plus reset sequence.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] ST  = 32'h8000_0000;
    localparam logic [31:0] RSV = 32'h8000_0004;
    localparam logic [31:0] TXD = 32'h8000_0008;
    localparam logic [31:0] RXD = 32'h8000_000C;
    localparam logic [31:0] NS  = 32'h0000_0008;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  wd;
        logic        we;
        logic        re;
        logic        st;
        logic        dir;
        logic [7:0]  dout;
        logic        dov;
        logic        chkRd;
        logic [31:0] expRd;
        logic [7:0]  expDi;
        logic        expDiv;
        logic        expDor;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic        stall;
    logic        sel;
    logic [31:0] rdata;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataInReady;
    logic [7:0]  DataOut;
    logic        DataOutValid;
    logic        DataOutReady;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    uart_mmio_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .re(re),
        .stall(stall),
        .sel(sel),
        .rdata(rdata),
        .DataIn(DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .DataOut(DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        logic [31:0] a, logic [7:0] wd, logic w, logic r, logic st,
        logic dir, logic [7:0] dout, logic dov, logic chkRd,
        logic [31:0] erd, logic [7:0] edi, logic ediv, logic edor);
        vec_t x;
        x.addr = a; x.wd = wd; x.we = w; x.re = r; x.st = st;
        x.dir = dir; x.dout = dout; x.dov = dov; x.chkRd = chkRd;
        x.expRd = erd; x.expDi = edi; x.expDiv = ediv; x.expDor = edor;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        addr = x.addr; wdata = x.wd; we = x.we; re = x.re;
        stall = x.st; DataInReady = x.dir;
        DataOut = x.dout; DataOutValid = x.dov;
    endtask

    task automatic idle();
        addr = ST; wdata = 8'h00; we = 1'b0; re = 1'b0; stall = 1'b0;
        DataInReady = 1'b0; DataOut = 8'h00; DataOutValid = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b0;

        // order/drain of three bytes
        vecs.push_back(v(ST, 8'h00,0,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h001,8'h00,0,1));
        vecs.push_back(v(TXD,8'h41,1,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(TXD,8'h42,1,0,0,0,8'h00,0,1,32'h000,8'h41,1,1));
        vecs.push_back(v(TXD,8'h43,1,0,0,0,8'h00,0,1,32'h000,8'h41,1,1));
        vecs.push_back(v(TXD,8'h00,0,1,0,0,8'h00,0,1,32'h000,8'h41,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h41,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h42,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h43,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h00,0,1));
        // overflow, sticky clear, flush vs pop
        vecs.push_back(v(TXD,8'h50,1,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(TXD,8'h51,1,0,0,0,8'h00,0,1,32'h000,8'h50,1,1));
        vecs.push_back(v(TXD,8'h52,1,0,0,0,8'h00,0,1,32'h000,8'h50,1,1));
        vecs.push_back(v(TXD,8'h53,1,0,0,0,8'h00,0,1,32'h000,8'h50,1,1));
        vecs.push_back(v(TXD,8'h54,1,0,0,0,8'h00,0,1,32'h000,8'h50,1,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h044,8'h50,1,1));
        vecs.push_back(v(ST, 8'h04,1,0,0,0,8'h00,0,1,32'h000,8'h50,1,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h040,8'h50,1,1));
        vecs.push_back(v(ST, 8'h10,1,0,0,1,8'h00,0,1,32'h000,8'h50,1,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,1,8'h00,0,1,32'h001,8'h00,0,1));
        // RX fill, drain, empty read
        vecs.push_back(v(ST, 8'h00,0,0,0,0,8'h10,1,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,0,8'h11,1,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,0,8'h12,1,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,0,8'h13,1,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h14,1,1,32'h403,8'h00,0,0));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h010,8'h00,0,0));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h011,8'h00,0,1));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h012,8'h00,0,1));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h013,8'h00,0,1));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h009,8'h00,0,1));
        vecs.push_back(v(ST, 8'h08,1,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h001,8'h00,0,1));
        // stall blocks CPU side, UART side keeps going
        vecs.push_back(v(TXD,8'h77,1,0,1,0,8'h20,1,1,32'h000,8'h00,0,1));
        vecs.push_back(v(RXD,8'h00,0,1,1,0,8'h21,1,0,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h203,8'h00,0,1));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h020,8'h00,0,1));
        vecs.push_back(v(RXD,8'h00,0,1,0,0,8'h00,0,1,32'h021,8'h00,0,1));
        // unselected, reserved, RXDATA write: no effect
        vecs.push_back(v(NS, 8'h99,1,1,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(RSV,8'h10,1,1,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(RXD,8'h55,1,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h001,8'h00,0,1));
        // push on full with pop is dropped; push+pop keeps order
        vecs.push_back(v(TXD,8'h60,1,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(TXD,8'h61,1,0,0,0,8'h00,0,1,32'h000,8'h60,1,1));
        vecs.push_back(v(TXD,8'h62,1,0,0,0,8'h00,0,1,32'h000,8'h60,1,1));
        vecs.push_back(v(TXD,8'h63,1,0,0,0,8'h00,0,1,32'h000,8'h60,1,1));
        vecs.push_back(v(TXD,8'h64,1,0,0,1,8'h00,0,1,32'h000,8'h60,1,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h035,8'h61,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h61,1,1));
        vecs.push_back(v(TXD,8'h65,1,0,0,1,8'h00,0,1,32'h000,8'h62,1,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,1,8'h00,0,1,32'h025,8'h63,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h65,1,1));
        vecs.push_back(v(ST, 8'h00,0,0,0,1,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h04,1,0,0,0,8'h00,0,1,32'h000,8'h00,0,1));
        vecs.push_back(v(ST, 8'h00,0,1,0,0,8'h00,0,1,32'h001,8'h00,0,1));

        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d sel", i), 32'(sel), 32'(vecs[i].addr[31:28] == 4'h8));
            if (vecs[i].chkRd)
                chk($sformatf("v%0d rdata", i), rdata, vecs[i].expRd);
            chk($sformatf("v%0d DataIn", i), 32'(DataIn), 32'(vecs[i].expDi));
            chk($sformatf("v%0d DataInValid", i), 32'(DataInValid), 32'(vecs[i].expDiv));
            chk($sformatf("v%0d DataOutReady", i), 32'(DataOutReady), 32'(vecs[i].expDor));
        end

        // reset asserted between edges with two entries in each FIFO
        @(negedge clk);
        idle();
        addr = TXD; we = 1'b1; wdata = 8'hB1;
        DataOut = 8'hC1; DataOutValid = 1'b1;
        @(negedge clk);
        wdata = 8'hB2; DataOut = 8'hC2;
        @(negedge clk);
        idle();
        re = 1'b1;
        #2;
        chk("pre-reset status", rdata, 32'h223);
        chk("pre-reset DataIn", 32'(DataIn), 32'hB1);
        re = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("async DataInValid", 32'(DataInValid), 32'h0);
        chk("async DataIn", 32'(DataIn), 32'h0);
        chk("async DataOutReady", 32'(DataOutReady), 32'h1);
        chk("async rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        re = 1'b1;
        #2;
        chk("post-reset status", rdata, 32'h001);
        addr = RXD;
        #1;
        chk("post-reset rx read", rdata, 32'h0);
        chk("post-reset DataInValid", 32'(DataInValid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
